// File: rtl/hcode_pack_32to128.sv
// Packs RATIO upstream ap_fifo words (little-endian lanes) into one wide word
// and presents it through a 2-entry ap_fifo-compatible output buffer.
// A flush pushes the pending partial word with its unfilled lanes zeroed.
module hcode_pack_32to128 #(
  parameter int IN_W  = 32,
  parameter int RATIO = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic [IN_W-1:0]         in_dout,
  input  logic                    in_empty_n,
  output logic                    in_read,
  output logic [IN_W*RATIO-1:0]   out_dout,
  output logic                    out_empty_n,
  input  logic                    out_read,
  input  logic                    flush
);

  localparam int          OUT_W = IN_W * RATIO;
  localparam int          ACC_W = (RATIO - 1) * IN_W;
  localparam int          CW    = $clog2(RATIO);
  localparam int unsigned LANES = RATIO - 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             flush_pend_q, flush_pend_d;
  logic [1:0]       occ_q, occ_d;
  logic [OUT_W-1:0] buf0_q, buf0_d;
  logic [OUT_W-1:0] buf1_q, buf1_d;
  logic             out_empty_n_q, out_empty_n_d;

  logic             pop, push, flush_req, space, do_flush;
  logic [OUT_W-1:0] word;

  // Upstream pop: only from inputs and registers, never from out_read.
  always_comb begin
    in_read = in_empty_n & ~ap_rst & ~flush & ~flush_pend_q &
              ((cnt_q != LAST) | (occ_q != 2'd2));
  end

  // Lane accumulation, flush handling and output buffer next state.
  always_comb begin
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    word          = '0;
    push          = 1'b0;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    occ_d         = occ_q;

    pop       = out_read & (occ_q != 2'd0);
    flush_req = (flush | flush_pend_q) & (cnt_q != '0);
    space     = (occ_q != 2'd2) | pop;
    do_flush  = flush_req & space;
    // A pending flush only ever exists with cnt>0, so it clears exactly
    // when the flush is performed.
    flush_pend_d = flush_req & ~space;

    if (do_flush) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (CW'(i) < cnt_q) word[i*IN_W +: IN_W] = acc_q[i*IN_W +: IN_W];
      end
      push  = 1'b1;
      cnt_d = '0;
      acc_d = '0;
    end else if (in_read) begin
      if (cnt_q == LAST) begin
        word  = {in_dout, acc_q};
        push  = 1'b1;
        cnt_d = '0;
      end else begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (CW'(i) == cnt_q) acc_d[i*IN_W +: IN_W] = in_dout;
        end
        cnt_d = cnt_q + 1'b1;
      end
    end

    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = word;
        else               buf1_d = word;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Only a flush can push at occ=2; the tail then moves up to head.
        if (occ_q == 2'd1) begin
          buf0_d = word;
        end else begin
          buf0_d = buf1_q;
          buf1_d = word;
        end
      end
      default: ;
    endcase

    out_empty_n_d = (occ_d != 2'd0);
  end

  // State registers with synchronous reset discarding all pending data.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q         <= '0;
      acc_q         <= '0;
      flush_pend_q  <= 1'b0;
      occ_q         <= 2'd0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      out_empty_n_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      flush_pend_q  <= flush_pend_d;
      occ_q         <= occ_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      out_empty_n_q <= out_empty_n_d;
    end
  end

  assign out_dout    = buf0_q;
  assign out_empty_n = out_empty_n_q;

endmodule

// File: tb/tb_hcode_pack_32to128.sv
// Directed bench for hcode_pack_32to128: packing, back-pressure, flush,
// deferred flush and mid-word reset.
module tb_hcode_pack_32to128;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [31:0]  in_dout;
  logic         in_empty_n;
  logic         in_read;
  logic [127:0] out_dout;
  logic         out_empty_n;
  logic         out_read;
  logic         flush;

  int checks = 0;
  int errors = 0;
  logic rd_seen;

  hcode_pack_32to128 #(.IN_W(32), .RATIO(4)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_dout     (in_dout),
    .in_empty_n  (in_empty_n),
    .in_read     (in_read),
    .out_dout    (out_dout),
    .out_empty_n (out_empty_n),
    .out_read    (out_read),
    .flush       (flush)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, capture in_read before the edge, return #1 after it.
  task automatic drive(input logic [31:0] d, input logic e, input logic r, input logic f);
    in_dout    = d;
    in_empty_n = e;
    out_read   = r;
    flush      = f;
    #1;
    rd_seen = in_read;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    ap_rst = 1'b1; in_dout = '0; in_empty_n = 1'b0; out_read = 1'b0; flush = 1'b0;

    // Reset state
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    chk("rst_in_read", {127'h0, rd_seen}, 128'h0);
    chk("rst_empty_n", {127'h0, out_empty_n}, 128'h0);
    chk("rst_dout", out_dout, 128'h0);
    ap_rst = 1'b0;

    // Back-to-back 8 words with out_read held
    for (int k = 1; k <= 8; k++) begin
      drive(32'(k), 1'b1, 1'b1, 1'b0);
      chk($sformatf("t1_in_read_%0d", k), {127'h0, rd_seen}, 128'h1);
      if (k == 3) chk("t1_empty_after3", {127'h0, out_empty_n}, 128'h0);
      if (k == 4) begin
        chk("t1_empty_after4", {127'h0, out_empty_n}, 128'h1);
        chk("t1_word1", out_dout, 128'h00000004_00000003_00000002_00000001);
      end
      if (k == 5) chk("t1_popped", {127'h0, out_empty_n}, 128'h0);
    end
    chk("t1_word2", out_dout, 128'h00000008_00000007_00000006_00000005);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_drained", {127'h0, out_empty_n}, 128'h0);

    // Back-pressure: 12 words with out_read=0
    for (int k = 0; k < 11; k++) begin
      drive(32'h10 + 32'(k), 1'b1, 1'b0, 1'b0);
      chk($sformatf("t2_in_read_%0d", k), {127'h0, rd_seen}, 128'h1);
    end
    drive(32'h1B, 1'b1, 1'b0, 1'b0);
    chk("t2_held", {127'h0, rd_seen}, 128'h0);
    chk("t2_head", out_dout, 128'h00000013_00000012_00000011_00000010);
    drive(32'h1B, 1'b1, 1'b1, 1'b0);
    chk("t2_no_out_read_path", {127'h0, rd_seen}, 128'h0);
    chk("t2_head_after_pop", out_dout, 128'h00000017_00000016_00000015_00000014);
    drive(32'h1B, 1'b1, 1'b0, 1'b0);
    chk("t2_12th_accepted", {127'h0, rd_seen}, 128'h1);
    chk("t2_head_kept", out_dout, 128'h00000017_00000016_00000015_00000014);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_third_word", out_dout, 128'h0000001B_0000001A_00000019_00000018);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_drained", {127'h0, out_empty_n}, 128'h0);

    // Flush of a 3-word partial
    drive(32'hA, 1'b1, 1'b0, 1'b0);
    drive(32'hB, 1'b1, 1'b0, 1'b0);
    drive(32'hC, 1'b1, 1'b0, 1'b0);
    chk("t3_no_word_yet", {127'h0, out_empty_n}, 128'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    chk("t3_flush_valid", {127'h0, out_empty_n}, 128'h1);
    chk("t3_flush_word", out_dout, 128'h00000000_0000000C_0000000B_0000000A);

    // Flush with cnt=0 does nothing
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    chk("t4_head_same", out_dout, 128'h00000000_0000000C_0000000B_0000000A);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_no_extra_word", {127'h0, out_empty_n}, 128'h0);

    // Deferred flush with a full buffer
    for (int k = 0; k < 10; k++) drive(32'h20 + 32'(k), 1'b1, 1'b0, 1'b0);
    chk("t5_cnt2_accept", {127'h0, rd_seen}, 128'h1);
    drive(32'h2A, 1'b1, 1'b0, 1'b1);
    chk("t5_flush_blocks", {127'h0, rd_seen}, 128'h0);
    drive(32'h2A, 1'b1, 1'b0, 1'b0);
    chk("t5_pend_blocks", {127'h0, rd_seen}, 128'h0);
    drive(32'h2A, 1'b1, 1'b1, 1'b0);
    chk("t5_pend_blocks_pop", {127'h0, rd_seen}, 128'h0);
    chk("t5_head_after_pop", out_dout, 128'h00000027_00000026_00000025_00000024);
    drive(32'h2A, 1'b1, 1'b0, 1'b0);
    chk("t5_pend_cleared", {127'h0, rd_seen}, 128'h1);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_padded", out_dout, 128'h00000000_00000000_00000029_00000028);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_drained", {127'h0, out_empty_n}, 128'h0);

    // Reset with cnt=2 and occ=1 (0x2A already in lane 0)
    drive(32'h2B, 1'b1, 1'b0, 1'b0);
    drive(32'h2C, 1'b1, 1'b0, 1'b0);
    drive(32'h2D, 1'b1, 1'b0, 1'b0);
    chk("t6_prefill", out_dout, 128'h0000002D_0000002C_0000002B_0000002A);
    drive(32'h2E, 1'b1, 1'b0, 1'b0);
    drive(32'h2F, 1'b1, 1'b0, 1'b0);
    ap_rst = 1'b1;
    drive(32'h30, 1'b1, 1'b0, 1'b0);
    chk("t6_rst_in_read", {127'h0, rd_seen}, 128'h0);
    chk("t6_rst_empty_n", {127'h0, out_empty_n}, 128'h0);
    ap_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(32'h40 + 32'(k), 1'b1, 1'b0, 1'b0);
      if (k == 2) chk("t6_no_stale", {127'h0, out_empty_n}, 128'h0);
    end
    chk("t6_new_word", out_dout, 128'h00000043_00000042_00000041_00000040);
    drive(32'h0, 1'b0, 1'b1, 1'b0);
    chk("t6_single_word", {127'h0, out_empty_n}, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
